// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM encodings and bit-period derivation,
// kept here so the receiver, a future transmitter and the bench agree.
package uart_rx_pkg;

   localparam int DEF_CLK_FREQ = 50000000;
   localparam int DEF_BAUD     = 115200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Integer-truncated clocks per bit; callers require the result >= 4.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial pin in, parallel byte and strobes out.
interface uart_rx_if #(
   parameter int D_WIDTH = 8
) ();
   logic               rx;
   logic [D_WIDTH-1:0] rx_data;
   logic               rx_done;
   logic               frame_err;
   logic               busy;

   modport master (
      input  rx,
      output rx_data, rx_done, frame_err, busy
   );

   modport slave (
      output rx,
      input  rx_data, rx_done, frame_err, busy
   );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-stage synchronizer for asynchronous single-bit inputs; reset value
// is chosen to match the input's idle level so reset causes no false edge.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized falling-edge start detect, mid-bit sampling
// from a bit-period counter, LSB first, one-cycle done / framing-error strobes.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD,
   parameter int D_WIDTH  = 8
) (
   input  logic       clk,
   input  logic       rst,
   uart_rx_if.master  bus
);
   localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CNT_W = $clog2(CPB);
   localparam int IDX_W = $clog2(D_WIDTH) + 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB/2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D_WIDTH - 1);

   rx_state_t          r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [D_WIDTH-1:0] r_shift, w_shift_nxt;
   logic [D_WIDTH-1:0] r_data, w_data_nxt;
   logic               r_done, w_done_nxt;
   logic               r_err, w_err_nxt;
   logic               r_rx_d;
   logic               w_rx_s;
   logic               w_start;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (bus.rx),
      .o_q (w_rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) r_rx_d <= 1'b1;
      else     r_rx_d <= w_rx_s;
   end

   // Edge, not level: a line stuck low must not start frame after frame.
   assign w_start = r_rx_d & ~w_rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (w_start) w_state_nxt = START;
         end
         START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt = '0;
               if (!w_rx_s) begin
                  w_state_nxt = DATA;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt = '0;
               // Shift in at the MSB: after D_WIDTH bits the first (LSB) lands in bit 0.
               w_shift_nxt = {w_rx_s, r_shift[D_WIDTH-1:1]};
               if (r_idx == IDX_LAST) w_state_nxt = STOP;
               else                   w_idx_nxt   = r_idx + IDX_W'(1);
            end
         end
         STOP: begin
            // Leave at mid stop bit so a back-to-back start edge is still seen.
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
               if (w_rx_s) begin
                  w_data_nxt = r_shift;
                  w_done_nxt = 1'b1;
               end else begin
                  w_err_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.rx_data   = r_data;
   assign bus.rx_done   = r_done;
   assign bus.frame_err = r_err;
   assign bus.busy      = (r_state != IDLE);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver feeding the memory controller's write path: converts the asynchronous rx pin into one parallel byte plus a single-cycle strobe (rx_data/rx_done). Fixed 8N1 framing, LSB first, mid-bit sampling from a bit-period counter. Sits between the board RX pin and the memory controller; its outputs connect one-to-one to that controller's rx_data/rx_done inputs.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz (DE0 board clock)
BAUD, 115200, line rate in bit/s
D_WIDTH, 8, data bits per frame
CLKS_PER_BIT, CLK_FREQ/BAUD (434), derived localparam, integer-truncated; must be >= 4

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  one clock; reset is synchronous and active-high
rx  in  1  asynchronous serial input, idle high
rx_data  out  D_WIDTH  last correctly framed byte; held until the next good frame
rx_done  out  1  one-cycle pulse, rx_data valid in the same cycle
frame_err  out  1  one-cycle pulse, stop bit sampled low
busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, counters=0, rx_data=0, rx_done=0, frame_err=0, busy=0, sync flops=1. Takes priority over everything, including mid-frame; the partial frame is discarded.
- rx passes through a 2-flop synchronizer, then one delay flop for edge detection. Start detect = delayed sample 1 and synced sample 0 (falling edge). A line held low does not retrigger.
- bit_cnt counts 0..CLKS_PER_BIT-1 and restarts at 0 on every state change.
- IDLE: on start detect -> START, bit_cnt=0.
- START: at bit_cnt == CLKS_PER_BIT/2-1 (mid start bit), sample synced rx. If 0 -> DATA, bit_idx=0. If 1 -> glitch: return to IDLE with no pulse.
- DATA: every CLKS_PER_BIT cycles, sample into shift register position bit_idx (LSB first). After bit_idx == D_WIDTH-1 -> STOP.
- STOP: after CLKS_PER_BIT cycles (mid stop bit), sample synced rx.
  - If 1: load rx_data from the shift register and pulse rx_done for exactly 1 cycle.
  - If 0: pulse frame_err for 1 cycle; rx_data is unchanged.
  - Both cases then go to IDLE.
- Returning to IDLE at mid stop bit allows back-to-back frames. A start edge in the cycle after the stop sample must be caught.
- rx_done and frame_err are never high together and are never high in consecutive cycles.
- Latency: rx_done asserts 2 (sync) + 1 (edge) + CLKS_PER_BIT/2 + (D_WIDTH+1)*CLKS_PER_BIT cycles after the rx falling edge at the pin, ±1 cycle of pin-to-clock phase.
- busy=0 only in IDLE.
- Width rules: bit_cnt width = $clog2(CLKS_PER_BIT); bit_idx width = $clog2(D_WIDTH)+1. No overflow is permitted; all compares use full width.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) and the CLKS_PER_BIT derivation, so the bench and a future uart_tx use the same values.
- One natural sub-module: sync_2ff (2-stage synchronizer, parameter reset value 1). Reuse it for push_sw debouncing inputs elsewhere.
- The FSM and datapath stay in uart_rx.

Test Plan:
All tests use CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16).
1. Reset then send 0xA5 (8N1, LSB first, 16 clk/bit) -> exactly one rx_done pulse ~2+1+8+144 cycles after the start edge; rx_data=8'hA5; frame_err stays 0.
2. Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three rx_done pulses; rx_data sequence 00, FF, 3C.
3. 4-cycle low glitch on idle rx -> no rx_done, no frame_err; busy returns to 0 by mid start bit.
4. Frame 0x55 with stop bit driven 0 -> frame_err pulse for 1 cycle, no rx_done; rx_data keeps the previous value (0x3C after test 2). With rx held low afterwards, no new frame starts until rx goes high then low.
5. rst asserted mid-DATA of frame 0x81 -> next cycle: busy=0, rx_data=0, no pulses. A following clean frame 0x81 is received correctly.
6. Feed rx_data/rx_done into the memory controller: five frames 0x11..0x55 -> exactly four writes of 0x11..0x44. The fifth byte is dropped because write address 4 blocks further writes.
